// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl
// Purpose  : ID-stage hazard/stall/flush control with a shadow EX/MEM/WB
//            pipeline and an MDU busy tracker. Optional macro:
//            STALL_CTRL_FORWARD_EN (only load-use and MDU stalls remain).
// Revision : 1.0 - initial release
// ============================================================================
module stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_use,
    input  logic       id_rt_use,
    input  logic [4:0] id_wd,
    input  logic       id_we,
    input  logic       id_load,
    input  logic       id_mdu_start,
    input  logic       id_mdu_div,
    input  logic       J_PC_en,
    input  logic       B_PC_en,
    output logic       detect_conflict,
    output logic       PC_bobl,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic       mdu_busy
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [4:0]         r_mdu_wd;

    logic [4:0]         r_ex_wd;
    logic               r_ex_we;
    logic               r_ex_load;
    logic [4:0]         r_mem_wd;
    logic               r_mem_we;
    logic [4:0]         r_wb_wd;
    logic               r_wb_we;

    logic               w_ex_hit;
    logic               w_load_use;
    logic               w_mdu_dep;
    logic               w_data_stall;
    logic               w_mdu_stall;
    logic               w_issue;
    logic               w_mdu_accept;

    // A producer only matters if it really writes a nonzero register that ID reads.
    function automatic logic f_src_hit(
        input logic [4:0] wd,
        input logic       we,
        input logic [4:0] rs,
        input logic       rs_use,
        input logic [4:0] rt,
        input logic       rt_use
    );
        f_src_hit = we && (wd != 5'd0) &&
                    ((rs_use && (rs == wd)) || (rt_use && (rt == wd)));
    endfunction

    assign w_ex_hit   = f_src_hit(r_ex_wd, r_ex_we, id_rs, id_rs_use, id_rt, id_rt_use);
    assign w_load_use = r_ex_load && w_ex_hit;
    assign w_mdu_dep  = f_src_hit(r_mdu_wd, 1'b1, id_rs, id_rs_use, id_rt, id_rt_use);

`ifdef STALL_CTRL_FORWARD_EN
    assign w_data_stall = id_valid && w_load_use;
`else
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit    = f_src_hit(r_mem_wd, r_mem_we, id_rs, id_rs_use, id_rt, id_rt_use);
    assign w_wb_hit     = f_src_hit(r_wb_wd, r_wb_we, id_rs, id_rs_use, id_rt, id_rt_use);
    assign w_data_stall = id_valid && (w_load_use || w_ex_hit || w_mem_hit || w_wb_hit);
`endif

    assign w_mdu_stall  = (r_state == S_BUSY) && id_valid && (id_mdu_start || w_mdu_dep);
    assign w_issue      = id_valid && !w_data_stall && !w_mdu_stall;
    assign w_mdu_accept = w_issue && id_mdu_start && (r_state == S_IDLE);

    assign detect_conflict = w_data_stall;
    assign PC_bobl         = w_mdu_stall;
    assign id_ex_bubble    = id_valid && (w_data_stall || w_mdu_stall);
    assign mdu_busy        = (r_state == S_BUSY);
    // Gated by rst_n so a redirect seen while in reset cannot leak out.
    assign if_id_flush     = rst_n && (J_PC_en || B_PC_en) && !w_data_stall && !w_mdu_stall;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_mdu_accept) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = id_mdu_div ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mdu_wd <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_mdu_accept) begin
                r_mdu_wd <= id_we ? id_wd : 5'd0;
            end
        end
    end

    // Shadow pipeline: a stalled or empty ID slot enters EX as an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_wd   <= 5'd0;
            r_ex_we   <= 1'b0;
            r_ex_load <= 1'b0;
            r_mem_wd  <= 5'd0;
            r_mem_we  <= 1'b0;
            r_wb_wd   <= 5'd0;
            r_wb_we   <= 1'b0;
        end else begin
            r_ex_wd   <= w_issue ? id_wd   : 5'd0;
            r_ex_we   <= w_issue ? id_we   : 1'b0;
            r_ex_load <= w_issue ? id_load : 1'b0;
            r_mem_wd  <= r_ex_wd;
            r_mem_we  <= r_ex_we;
            r_wb_wd   <= r_mem_wd;
            r_wb_we   <= r_mem_we;
        end
    end

endmodule
`default_nettype wire
